// File: rtl/copperv_pkg.sv
// Shared types for the copperv memory side: arbiter FSM states and grant owner.
package copperv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        arb_grant_inst = 1'b0,
        arb_grant_data = 1'b1
    } arb_grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one shared bus, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants; default is data-over-fetch priority.
module mem_arbiter
    import copperv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [STRB_WIDTH-1:0] d_req_strb,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_req_we,
    output logic [DATA_WIDTH-1:0] m_req_wdata,
    output logic [STRB_WIDTH-1:0] m_req_strb,
    input  logic                  m_resp_valid,
    input  logic [DATA_WIDTH-1:0] m_resp_data
);

    // Handshakes: a requester transfer happens in the cycle its valid and ready are
    // both high (ready is a one-cycle pulse, only in ARB_IDLE); the bus request
    // transfers when m_req_valid and m_req_ready are both high; responses are
    // one-cycle valid pulses with no back-pressure.
    arb_state_e state, state_next;
    arb_grant_e grant, grant_next;
    logic       take;
    logic       data_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_grant_e last_grant;

    always_comb data_wins = d_req_valid && (!i_req_valid || last_grant == arb_grant_inst);

    // Reset value points the next contended grant at the data side.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= arb_grant_inst;
        else if (take)
            last_grant <= grant_next;
    end
`else
    always_comb data_wins = d_req_valid;
`endif

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        take        = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!rst && (i_req_valid || d_req_valid)) begin
                    take        = 1'b1;
                    grant_next  = data_wins ? arb_grant_data : arb_grant_inst;
                    d_req_ready = data_wins;
                    i_req_ready = !data_wins;
                    state_next  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (m_req_ready)
                    state_next = ARB_RESP;
            end
            ARB_RESP: begin
                if (m_resp_valid)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign m_req_valid = (state == ARB_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            grant        <= arb_grant_data;
            m_req_addr   <= '0;
            m_req_we     <= 1'b0;
            m_req_wdata  <= '0;
            m_req_strb   <= '0;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            i_resp_valid <= 1'b0;
            d_resp_valid <= 1'b0;
            if (take) begin
                if (data_wins) begin
                    m_req_addr  <= d_req_addr;
                    m_req_we    <= d_req_we;
                    m_req_wdata <= d_req_wdata;
                    m_req_strb  <= d_req_strb;
                end else begin
                    // Fetches are always reads with no byte enables.
                    m_req_addr  <= i_req_addr;
                    m_req_we    <= 1'b0;
                    m_req_wdata <= '0;
                    m_req_strb  <= '0;
                end
            end
            if (state == ARB_RESP && m_resp_valid) begin
                if (grant == arb_grant_data) begin
                    d_resp_valid <= 1'b1;
                    d_resp_data  <= m_req_we ? '0 : m_resp_data;
                end else begin
                    i_resp_valid <= 1'b1;
                    i_resp_data  <= m_resp_data;
                end
            end
        end
    end

endmodule
